// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory between an instruction-fetch port and a
// data port, with data priority, fetch starvation relief and flush squashing.
module mem_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              dm_req_i,
   input  logic [3:0]        dm_we_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [31:0]       dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [31:0]       dm_rdata_o,
   input  logic              flush_i,
   output logic              mem_en_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_din_o,
   input  logic [31:0]       mem_dout_i
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   owner_t            rd_owner_r;
   owner_t            rd_owner_nxt_s;
   logic [CNT_W-1:0]  starve_cnt_r;
   logic [CNT_W-1:0]  starve_cnt_nxt_s;
   logic              if_gnt_s;
   logic              dm_gnt_s;
   logic              addr_unused_s;

   // Byte-offset and high address bits never reach the word-addressed memory.
   assign addr_unused_s = ^{if_addr_i[1:0], if_addr_i[31:ADDR_W+2],
                            dm_addr_i[1:0], dm_addr_i[31:ADDR_W+2]};

   // Grant selection: data wins unless fetch has been starved long enough.
   always_comb begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
      if (rst) begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end else begin
         if_gnt_s = if_req_i & ~flush_i & (~dm_req_i | (starve_cnt_r == LIMIT_C));
         dm_gnt_s = dm_req_i & ~if_gnt_s;
      end
   end

   // Route the granted port onto the memory in the same cycle.
   always_comb begin
      if_gnt_o   = if_gnt_s;
      dm_gnt_o   = dm_gnt_s;
      mem_en_o   = if_gnt_s | dm_gnt_s;
      mem_din_o  = dm_wdata_i;
      mem_we_o   = 4'b0000;
      mem_addr_o = dm_addr_i[ADDR_W+1:2];
      if (if_gnt_s) begin
         mem_addr_o = if_addr_i[ADDR_W+1:2];
      end else if (dm_gnt_s) begin
         mem_we_o   = dm_we_i;
      end else begin
         mem_we_o   = 4'b0000;
      end
   end

   // Next-state for the starvation counter and the read-response owner.
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      rd_owner_nxt_s   = OWN_NONE;
      if (if_gnt_s | ~if_req_i | flush_i) begin
         starve_cnt_nxt_s = {CNT_W{1'b0}};
      end else if (starve_cnt_r != LIMIT_C) begin
         starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
      if (if_gnt_s) begin
         rd_owner_nxt_s = OWN_IF;
      end else if (dm_gnt_s && (dm_we_i == 4'b0000)) begin
         rd_owner_nxt_s = OWN_DM;
      end else begin
         rd_owner_nxt_s = OWN_NONE;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner_r   <= OWN_NONE;
         starve_cnt_r <= {CNT_W{1'b0}};
      end else begin
         rd_owner_r   <= rd_owner_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
      end
   end

   // Steer memory read data to the owner; reset and flush squash in-flight responses.
   always_comb begin
      if_rvalid_o = 1'b0;
      if_rdata_o  = 32'h0000_0000;
      dm_rvalid_o = 1'b0;
      dm_rdata_o  = 32'h0000_0000;
      case (rd_owner_r)
         OWN_IF: begin
            if (~rst & ~flush_i) begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_dout_i;
            end else begin
               if_rvalid_o = 1'b0;
               if_rdata_o  = 32'h0000_0000;
            end
         end
         OWN_DM: begin
            if (~rst) begin
               dm_rvalid_o = 1'b1;
               dm_rdata_o  = mem_dout_i;
            end else begin
               dm_rvalid_o = 1'b0;
               dm_rdata_o  = 32'h0000_0000;
            end
         end
         default: begin
            if_rvalid_o = 1'b0;
            dm_rvalid_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency
// byte-writable memory model attached to the shared port.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i;
   logic [3:0]  dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_gnt_o;
   logic        dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        flush_i;
   logic        mem_en_o;
   logic [3:0]  mem_we_o;
   logic [13:0] mem_addr_o;
   logic [31:0] mem_din_o;
   logic [31:0] mem_dout;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:16383];

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .flush_i(flush_i),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_din_o(mem_din_o), .mem_dout_i(mem_dout)
   );

   always #5 clk = ~clk;

   // Memory model: read-first, byte write enables, data one cycle after enable.
   always @(posedge clk) begin
      if (mem_en_o) begin
         for (int b = 0; b < 4; b++)
            if (mem_we_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
         mem_dout <= mem[mem_addr_o];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      if_req_i   = 1'b0;
      if_addr_i  = 32'h0000_0000;
      dm_req_i   = 1'b0;
      dm_we_i    = 4'b0000;
      dm_addr_i  = 32'h0000_0000;
      dm_wdata_i = 32'h0000_0000;
      flush_i    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 4'hF;
      #3;
      checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt_o); end
      checks++; if (dm_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_dm_gnt: got %b want 0", dm_gnt_o); end
      checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en_o); end
      checks++; if (mem_we_o !== 4'h0) begin errors++; $display("FAIL rst_mem_we: got %h want 0", mem_we_o); end
      tick();
      rst = 1'b0; set_idle();
      #3;
      checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {if_rvalid_o, dm_rvalid_o}); end
      checks++; if ({if_rdata_o, dm_rdata_o} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata_o, dm_rdata_o}); end
      tick();
   endtask

   task automatic test_fetch();
      if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
      #3;
      checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b want 1", if_gnt_o); end
      checks++; if (mem_addr_o !== 14'd4) begin errors++; $display("FAIL fetch_addr: got %0d want 4", mem_addr_o); end
      checks++; if ({mem_en_o, mem_we_o} !== 5'b1_0000) begin errors++; $display("FAIL fetch_en_we: got %b want 10000", {mem_en_o, mem_we_o}); end
      tick();
      if_req_i = 1'b0;
      #3;
      checks++; if (if_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %b want 1", if_rvalid_o); end
      checks++; if (if_rdata_o !== 32'h0000_0013) begin errors++; $display("FAIL fetch_rdata: got %h want 00000013", if_rdata_o); end
      checks++; if ({dm_rvalid_o, dm_rdata_o} !== 33'h0) begin errors++; $display("FAIL fetch_dm_quiet: got %h want 0", {dm_rvalid_o, dm_rdata_o}); end
      tick();
   endtask

   task automatic test_write();
      if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
      dm_req_i = 1'b1; dm_we_i = 4'b1111; dm_addr_i = 32'h0000_0020; dm_wdata_i = 32'hDEAD_BEEF;
      #3;
      checks++; if ({if_gnt_o, dm_gnt_o} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", {if_gnt_o, dm_gnt_o}); end
      checks++; if (mem_we_o !== 4'hF) begin errors++; $display("FAIL wr_we: got %h want f", mem_we_o); end
      checks++; if (mem_addr_o !== 14'd8) begin errors++; $display("FAIL wr_addr: got %0d want 8", mem_addr_o); end
      checks++; if (mem_din_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_din: got %h want deadbeef", mem_din_o); end
      tick();
      if_req_i = 1'b0; dm_we_i = 4'b0011; dm_addr_i = 32'h0000_0022; dm_wdata_i = 32'h1234_5678;
      #3;
      checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b want 00", {if_rvalid_o, dm_rvalid_o}); end
      checks++; if ({mem_we_o, mem_addr_o} !== {4'b0011, 14'd8}) begin errors++; $display("FAIL wr_mask: got %h/%0d want 3/8", mem_we_o, mem_addr_o); end
      tick();
      dm_we_i = 4'b0000; dm_addr_i = 32'h0000_0023;
      #3;
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr2_no_rvalid: got %b want 0", dm_rvalid_o); end
      tick();
      set_idle();
      #3;
      checks++; if (dm_rvalid_o !== 1'b1) begin errors++; $display("FAIL rdback_rvalid: got %b want 1", dm_rvalid_o); end
      checks++; if (dm_rdata_o !== 32'hDEAD_5678) begin errors++; $display("FAIL rdback_data: got %h want dead5678", dm_rdata_o); end
      tick();
   endtask

   task automatic test_starve();
      logic [4:0] exp_dm;
      logic [4:0] exp_if;
      exp_dm = 5'b10111;
      exp_if = 5'b01000;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
            dm_req_i = 1'b1; dm_we_i = 4'b0000; dm_addr_i = 32'h0000_0040;
         end else begin
            set_idle();
         end
         #3;
         if (i < 5) begin
            checks++; if ({if_gnt_o, dm_gnt_o} !== {exp_if[i], exp_dm[i]}) begin errors++; $display("FAIL starve_gnt c%0d: got %b want %b", i, {if_gnt_o, dm_gnt_o}, {exp_if[i], exp_dm[i]}); end
            checks++; if (mem_addr_o !== (exp_if[i] ? 14'd4 : 14'd16)) begin errors++; $display("FAIL starve_addr c%0d: got %0d", i, mem_addr_o); end
         end
         if (i > 0) begin
            checks++; if ({if_rvalid_o, dm_rvalid_o} !== {exp_if[i-1], exp_dm[i-1]}) begin errors++; $display("FAIL starve_rvalid c%0d: got %b want %b", i, {if_rvalid_o, dm_rvalid_o}, {exp_if[i-1], exp_dm[i-1]}); end
            checks++; if (dm_rdata_o !== (exp_dm[i-1] ? 32'h0BAD_F00D : 32'h0)) begin errors++; $display("FAIL starve_dm_rdata c%0d: got %h", i, dm_rdata_o); end
            checks++; if (if_rdata_o !== (exp_if[i-1] ? 32'h0000_0013 : 32'h0)) begin errors++; $display("FAIL starve_if_rdata c%0d: got %h", i, if_rdata_o); end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
      #3;
      checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_c0_gnt: got %b want 1", if_gnt_o); end
      tick();
      flush_i = 1'b1;
      #3;
      checks++; if ({if_gnt_o, if_rvalid_o, mem_en_o} !== 3'b000) begin errors++; $display("FAIL flush_c1: gnt/rvalid/en got %b want 000", {if_gnt_o, if_rvalid_o, mem_en_o}); end
      checks++; if (if_rdata_o !== 32'h0) begin errors++; $display("FAIL flush_rdata: got %h want 0", if_rdata_o); end
      tick();
      // Cycles 2..6: counter restarts from 0, saturates at cycle 5 where flush overrides it.
      for (int i = 2; i < 7; i++) begin
         if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 4'b0000; dm_addr_i = 32'h0000_0040;
         flush_i = (i == 5);
         #3;
         checks++; if ({if_gnt_o, dm_gnt_o} !== 2'b01) begin errors++; $display("FAIL flush_gnt c%0d: got %b want 01", i, {if_gnt_o, dm_gnt_o}); end
         tick();
      end
      set_idle();
      tick();
   endtask

   task automatic test_reset_inflight();
      dm_req_i = 1'b1; dm_we_i = 4'b0000; dm_addr_i = 32'h0000_0040;
      #3;
      checks++; if (dm_gnt_o !== 1'b1) begin errors++; $display("FAIL rstif_gnt: got %b want 1", dm_gnt_o); end
      tick();
      rst = 1'b1;
      #3;
      checks++; if ({dm_rvalid_o, mem_en_o, dm_gnt_o} !== 3'b000) begin errors++; $display("FAIL rstif_c1: rvalid/en/gnt got %b want 000", {dm_rvalid_o, mem_en_o, dm_gnt_o}); end
      checks++; if (dm_rdata_o !== 32'h0) begin errors++; $display("FAIL rstif_rdata: got %h want 0", dm_rdata_o); end
      tick();
      rst = 1'b0; set_idle();
      #3;
      checks++; if (dm_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstif_c2_rvalid: got %b want 0", dm_rvalid_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  we_t   [0:4];
      logic [31:0] addr_t [0:4];
      logic [31:0] wd_t   [0:4];
      logic [31:0] rd_t   [0:4];
      logic        exp_v;
      we_t = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
      addr_t = '{32'h0, 32'h4, 32'h4, 32'h0, 32'h0};
      wd_t = '{32'h0, 32'hCAFE_0004, 32'h0, 32'h5555_AAAA, 32'h0};
      rd_t = '{32'h1111_0000, 32'h0, 32'hCAFE_0004, 32'h0, 32'h5555_AAAA};
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            dm_req_i = 1'b1; dm_we_i = we_t[i]; dm_addr_i = addr_t[i]; dm_wdata_i = wd_t[i];
         end else begin
            set_idle();
         end
         #3;
         if (i < 5) begin
            checks++; if ({mem_en_o, dm_gnt_o} !== 2'b11) begin errors++; $display("FAIL b2b_en c%0d: got %b want 11", i, {mem_en_o, dm_gnt_o}); end
         end
         if (i > 0) begin
            exp_v = (we_t[i-1] == 4'h0);
            checks++; if (dm_rvalid_o !== exp_v) begin errors++; $display("FAIL b2b_rvalid c%0d: got %b want %b", i, dm_rvalid_o, exp_v); end
            checks++; if (dm_rdata_o !== (exp_v ? rd_t[i-1] : 32'h0)) begin errors++; $display("FAIL b2b_rdata c%0d: got %h want %h", i, dm_rdata_o, exp_v ? rd_t[i-1] : 32'h0); end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0000_0000;
      mem[0]  = 32'h1111_0000;
      mem[4]  = 32'h0000_0013;
      mem[16] = 32'h0BAD_F00D;
      tick();
      test_reset();
      test_fetch();
      test_write();
      test_starve();
      test_flush();
      test_reset_inflight();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: memory word-address width; memory depth 2^ADDR_W words.
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive denied fetch cycles before fetch outranks data.
REQ-003 clk  input  1  single core clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req_i  input  1  fetch read request.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_gnt_o  output  1  fetch granted this cycle.
REQ-008 if_rvalid_o  output  1  fetch read data valid.
REQ-009 if_rdata_o  output  32  fetch read data.
REQ-010 dm_req_i  input  1  data-port request.
REQ-011 dm_we_i  input  4  byte write mask; 0 means read.
REQ-012 dm_addr_i  input  32  data byte address.
REQ-013 dm_wdata_i  input  32  store data.
REQ-014 dm_gnt_o  output  1  data granted this cycle.
REQ-015 dm_rvalid_o  output  1  load data valid.
REQ-016 dm_rdata_o  output  32  load data.
REQ-017 flush_i  input  1  branch/jump redirect; squashes fetch traffic.
REQ-018 mem_en_o  output  1  shared single-port memory enable.
REQ-019 mem_we_o  output  4  memory byte write enable.
REQ-020 mem_addr_o  output  ADDR_W  memory word address.
REQ-021 mem_din_o  output  32  memory write data.
REQ-022 mem_dout_i  input  32  memory read data, valid one cycle after enable.

Function
REQ-023 Grants SHALL be combinational from requests and registered state; at most one of if_gnt_o/dm_gnt_o high per cycle.
REQ-024 Default priority: data over fetch; fetch SHALL win only when starve_cnt == STARVE_LIMIT.
REQ-025 flush_i high SHALL force if_gnt_o=0 that cycle regardless of starve_cnt.
REQ-026 Granted port SHALL drive memory same cycle: mem_en_o=1, mem_addr_o=addr[ADDR_W+1:2], mem_we_o=dm_we_i for data (0 for fetch), mem_din_o=dm_wdata_i; address bits [1:0] ignored.
REQ-027 No grant: mem_en_o=0, mem_we_o=0; mem_addr_o/mem_din_o don't-care.
REQ-028 Register rd_owner {NONE, IF, DM} SHALL record the read grant of the previous cycle; writes record NONE.
REQ-029 Read latency exactly 1 cycle: rd_owner==DM -> dm_rvalid_o=1, dm_rdata_o=mem_dout_i; rd_owner==IF -> if_rvalid_o=1, if_rdata_o=mem_dout_i unless flush_i high that cycle.
REQ-030 Non-owner rdata outputs SHALL be 0; rvalid never high for writes.
REQ-031 Back-to-back grants SHALL be supported every cycle; throughput one access/cycle.
REQ-032 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment when if_req_i & ~if_gnt_o & ~flush_i, saturate at STARVE_LIMIT, clear on if_gnt_o or ~if_req_i or flush_i.
REQ-033 Simultaneous if_req_i and dm_req_i with starve_cnt<STARVE_LIMIT: data granted, counter increments.
REQ-034 Requests SHALL be held by requester until granted; arbiter keeps no request queue.

Reset
REQ-035 While rst high: all grants 0, mem_en_o=0, mem_we_o=0, regardless of requests.
REQ-036 First rising edge with rst high: rd_owner=NONE, starve_cnt=0; next cycle if_rvalid_o=dm_rvalid_o=0, rdata outputs 0.
REQ-037 Reset during an in-flight read SHALL drop the response (no rvalid after reset).

Verification
REQ-038 Fetch only, if_addr_i=0x0000_0010, mem holds 0x0000_0013 at word 4 -> cycle 0 if_gnt_o=1, mem_addr_o=4; cycle 1 if_rvalid_o=1, if_rdata_o=0x0000_0013.
REQ-039 Both request, dm_we_i=4'b1111, dm_addr_i=0x20, dm_wdata_i=0xDEADBEEF -> dm_gnt_o=1, mem_we_o=4'hF, mem_addr_o=8, if_gnt_o=0; next cycle no rvalid.
REQ-040 dm_req_i held high with reads for 5 cycles, if_req_i high -> dm granted cycles 0-2, if granted cycle 3 (starve_cnt=3), dm cycle 4; rvalids follow each by one cycle.
REQ-041 Fetch granted cycle 0, flush_i=1 cycle 1 -> if_rvalid_o=0 cycle 1, if_gnt_o=0 cycle 1, starve_cnt=0.
REQ-042 Data read granted cycle 0, rst=1 cycle 1 -> dm_rvalid_o=0 cycle 1 and 2, mem_en_o=0 cycle 1.
REQ-043 Alternating dm read/write each cycle at addresses 0x0,0x4 -> dm_rvalid_o only after read grants, mem_en_o high every cycle.
